// File: rtl/key_pkg.sv
// Shared types and default timing constants for the multi-key debouncer.
// Values assume a 50 MHz sys_clk.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_fsm_e;

    localparam int KEY_DB_20MS_50M   = 32'd1_000_000;
    localparam int KEY_LONG_1S_50M   = 32'd50_000_000;
    localparam int KEY_REP_100MS_50M = 32'd5_000_000;

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, press/release debounce FSM and
// hold counter driving single-cycle press/release/long/repeat pulses.
module key_channel
    import key_pkg::*;
#(
    parameter int CNT_W        = 26,
    parameter int DEBOUNCE_CNT = KEY_DB_20MS_50M,
    parameter int LONG_CNT     = KEY_LONG_1S_50M,
    parameter int REPEAT_CNT   = KEY_REP_100MS_50M,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic press_flag,
    output logic release_flag,
    output logic long_flag,
    output logic repeat_flag
);

    localparam logic             REL_LVL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             REP_ON    = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

    logic [1:0]       sync_r;
    logic             k_s;
    key_fsm_e         state_r, state_nxt_s;
    logic [CNT_W-1:0] db_cnt_r, db_cnt_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic             long_done_r, long_done_nxt_s;
    logic             key_state_r, key_state_nxt_s;
    logic             press_nxt_s, release_nxt_s, long_nxt_s, repeat_nxt_s;
    logic             press_r, release_r, long_r, repeat_r;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_r <= {REL_LVL, REL_LVL};
        end else begin
            sync_r <= {sync_r[0], key_in};
        end
    end

    assign k_s = sync_r[1] ^ REL_LVL;

    // Next-state, counter and flag decode for the debounce FSM.
    always_comb begin
        state_nxt_s     = state_r;
        db_cnt_nxt_s    = db_cnt_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        long_done_nxt_s = long_done_r;
        key_state_nxt_s = key_state_r;
        press_nxt_s     = 1'b0;
        release_nxt_s   = 1'b0;
        long_nxt_s      = 1'b0;
        repeat_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                key_state_nxt_s = 1'b0;
                if (k_s) begin
                    state_nxt_s  = PRESS_DB;
                    db_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS_DB: begin
                if (!k_s) begin
                    state_nxt_s = IDLE;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nxt_s     = HELD;
                    press_nxt_s     = 1'b1;
                    key_state_nxt_s = 1'b1;
                    hold_cnt_nxt_s  = CNT_ZERO;
                    long_done_nxt_s = 1'b0;
                end else begin
                    db_cnt_nxt_s = db_cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (!k_s) begin
                    state_nxt_s  = RELEASE_DB;
                    db_cnt_nxt_s = CNT_ZERO;
                end else if (!long_done_r && (hold_cnt_r == LONG_LAST)) begin
                    long_nxt_s      = 1'b1;
                    long_done_nxt_s = 1'b1;
                    hold_cnt_nxt_s  = CNT_ZERO;
                end else if (long_done_r && (hold_cnt_r == REP_LAST)) begin
                    // Without repeat the counter parks at its terminal count.
                    repeat_nxt_s   = REP_ON;
                    hold_cnt_nxt_s = REP_ON ? CNT_ZERO : hold_cnt_r;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
                end
            end
            RELEASE_DB: begin
                if (k_s) begin
                    state_nxt_s = HELD;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nxt_s     = IDLE;
                    release_nxt_s   = 1'b1;
                    key_state_nxt_s = 1'b0;
                end else begin
                    db_cnt_nxt_s = db_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                db_cnt_nxt_s    = CNT_ZERO;
                hold_cnt_nxt_s  = CNT_ZERO;
                long_done_nxt_s = 1'b0;
                key_state_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= IDLE;
            db_cnt_r    <= CNT_ZERO;
            hold_cnt_r  <= CNT_ZERO;
            long_done_r <= 1'b0;
            key_state_r <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            long_r      <= 1'b0;
            repeat_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            db_cnt_r    <= db_cnt_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            long_done_r <= long_done_nxt_s;
            key_state_r <= key_state_nxt_s;
            press_r     <= press_nxt_s;
            release_r   <= release_nxt_s;
            long_r      <= long_nxt_s;
            repeat_r    <= repeat_nxt_s;
        end
    end

    assign key_state    = key_state_r;
    assign press_flag   = press_r;
    assign release_flag = release_r;
    assign long_flag    = long_r;
    assign repeat_flag  = repeat_r;

endmodule

// File: rtl/key_debounce_array.sv
// NUM_KEYS independent debounced key channels; the top only slices buses
// and rejects unusable timing parameters at elaboration.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int CNT_W        = 26,
    parameter int DEBOUNCE_CNT = KEY_DB_20MS_50M,
    parameter int LONG_CNT     = KEY_LONG_1S_50M,
    parameter int REPEAT_CNT   = KEY_REP_100MS_50M,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_flag,
    output logic [NUM_KEYS-1:0] release_flag,
    output logic [NUM_KEYS-1:0] long_flag,
    output logic [NUM_KEYS-1:0] repeat_flag
);

    localparam longint CNT_LIMIT = 64'd1 << CNT_W;

    if (NUM_KEYS < 1) begin : g_bad_num_keys
        $fatal(1, "key_debounce_array: NUM_KEYS must be >= 1");
    end
    if (DEBOUNCE_CNT < 2 || LONG_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_min
        $fatal(1, "key_debounce_array: DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT must be >= 2");
    end
    if (longint'(DEBOUNCE_CNT) >= CNT_LIMIT || longint'(LONG_CNT) >= CNT_LIMIT ||
        longint'(REPEAT_CNT) >= CNT_LIMIT) begin : g_bad_width
        $fatal(1, "key_debounce_array: counts must fit in CNT_W bits");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .CNT_W        (CNT_W),
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .LONG_CNT     (LONG_CNT),
            .REPEAT_CNT   (REPEAT_CNT),
            .REPEAT_EN    (REPEAT_EN),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .key_in       (key_in[i]),
            .key_state    (key_state[i]),
            .press_flag   (press_flag[i]),
            .release_flag (release_flag[i]),
            .long_flag    (long_flag[i]),
            .repeat_flag  (repeat_flag[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench: expected flag events are queued when keys are driven and
// matched against observed pulses on two DUTs (repeat enabled / disabled).
module tb_key_debounce_array;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [1:0] key_in;
    logic [1:0] key_state, press_flag, release_flag, long_flag, repeat_flag;
    logic [1:0] nr_key_state, nr_press, nr_release, nr_long, nr_repeat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // kind: 0 press, 1 long, 2 repeat, 3 release; +4 for the no-repeat DUT
    typedef struct {
        int         cyc;
        int         kind;
        logic [1:0] val;
    } exp_t;
    exp_t exp_q[$];

    key_debounce_array #(
        .NUM_KEYS(2), .CNT_W(26), .DEBOUNCE_CNT(8), .LONG_CNT(40),
        .REPEAT_CNT(10), .REPEAT_EN(1), .ACTIVE_LOW(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_state(key_state), .press_flag(press_flag), .release_flag(release_flag),
        .long_flag(long_flag), .repeat_flag(repeat_flag)
    );

    key_debounce_array #(
        .NUM_KEYS(2), .CNT_W(26), .DEBOUNCE_CNT(8), .LONG_CNT(40),
        .REPEAT_CNT(10), .REPEAT_EN(0), .ACTIVE_LOW(1)
    ) dut_nr (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_state(nr_key_state), .press_flag(nr_press), .release_flag(nr_release),
        .long_flag(nr_long), .repeat_flag(nr_repeat)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int c, input int k, input logic [1:0] v);
        exp_t e;
        int   pos;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        pos    = exp_q.size();
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc * 8 + exp_q[i].kind > c * 8 + k) pos = i;
        end
        exp_q.insert(pos, e);
    endfunction

    // Both DUTs share press/long/release timing; only repeat differs.
    function automatic void exp_pair(input int c, input int k, input logic [1:0] v);
        push_exp(c, k, v);
        if (k != 2) push_exp(c, k + 4, v);
    endfunction

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    // Monitor: every nonzero flag bus is one observed event.
    always @(negedge sys_clk) begin : mon
        logic [1:0] obs [8];
        exp_t       e;
        obs[0] = press_flag; obs[1] = long_flag; obs[2] = repeat_flag; obs[3] = release_flag;
        obs[4] = nr_press;   obs[5] = nr_long;   obs[6] = nr_repeat;   obs[7] = nr_release;
        for (int k = 0; k < 8; k++) begin
            if (obs[k] != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_evt_k%0d", k), obs[k], 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("evt_cyc_k%0d", e.kind), cyc, e.cyc);
                    chk($sformatf("evt_kind_k%0d", e.kind), k, e.kind);
                    chk($sformatf("evt_val_k%0d", e.kind), obs[k], e.val);
                end
            end
        end
    end

    initial begin : stim
        int c, p, d, r;
        sys_rst_n = 1'b0;
        key_in    = 2'b11;
        repeat (3) @(negedge sys_clk);
        chk("rst_outputs", {key_state, press_flag, release_flag, long_flag, repeat_flag}, 0);
        chk("rst_outputs_nr", {nr_key_state, nr_press, nr_release, nr_long, nr_repeat}, 0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        chk("post_rst_state", key_state, 0);

        // 1: basic press and release on key 0
        c = cyc; key_in[0] = 1'b0;
        exp_pair(c + 11, 0, 2'b01);
        wait_to(c + 10); chk("t1_state_pre", key_state, 2'b00);
        wait_to(c + 11); chk("t1_state_press", key_state, 2'b01);
        d = cyc; key_in[0] = 1'b1;
        exp_pair(d + 11, 3, 2'b01);
        wait_to(d + 10); chk("t1_state_pre_rel", key_state, 2'b01);
        wait_to(d + 11); chk("t1_state_rel", key_state, 2'b00);
        wait_to(cyc + 10);

        // 2: bouncing press is rejected, stable press accepted
        for (int i = 0; i < 3; i++) begin
            key_in[0] = 1'b0; repeat (5) @(negedge sys_clk);
            key_in[0] = 1'b1; repeat (5) @(negedge sys_clk);
            chk("t2_bounce_state", key_state, 2'b00);
        end
        c = cyc; key_in[0] = 1'b0;
        exp_pair(c + 11, 0, 2'b01);
        wait_to(c + 11); chk("t2_state_press", key_state, 2'b01);
        d = cyc; key_in[0] = 1'b1;
        exp_pair(d + 11, 3, 2'b01);
        wait_to(d + 12); chk("t2_state_rel", key_state, 2'b00);
        wait_to(cyc + 10);

        // 3: long press then six repeats (none on the no-repeat DUT)
        c = cyc; key_in[0] = 1'b0; p = c + 11;
        exp_pair(p, 0, 2'b01);
        exp_pair(p + 40, 1, 2'b01);
        for (int i = 1; i <= 6; i++) push_exp(p + 40 + 10 * i, 2, 2'b01);
        wait_to(p + 99); chk("t3_state_held", key_state, 2'b01);
        wait_to(p + 100);
        d = cyc; key_in[0] = 1'b1;
        exp_pair(d + 11, 3, 2'b01);
        wait_to(d + 12); chk("t3_state_rel", key_state, 2'b00);
        chk("t3_nr_state_rel", nr_key_state, 2'b00);
        wait_to(cyc + 10);

        // 4: short release glitch while held is ignored
        c = cyc; key_in[0] = 1'b0; p = c + 11;
        exp_pair(p, 0, 2'b01);
        wait_to(p + 5); key_in[0] = 1'b1;
        wait_to(p + 8); key_in[0] = 1'b0;
        wait_to(p + 15); chk("t4_glitch_state", key_state, 2'b01);
        wait_to(p + 20);
        d = cyc; key_in[0] = 1'b1;
        exp_pair(d + 11, 3, 2'b01);
        wait_to(d + 10); chk("t4_state_pre_rel", key_state, 2'b01);
        wait_to(d + 11); chk("t4_state_rel", key_state, 2'b00);
        wait_to(cyc + 10);

        // 5: identical stimulus on both keys
        c = cyc; key_in = 2'b00; p = c + 11;
        exp_pair(p, 0, 2'b11);
        exp_pair(p + 40, 1, 2'b11);
        wait_to(p + 20); chk("t5_state_both", key_state, 2'b11);
        wait_to(p + 40);
        key_in = 2'b11;
        exp_pair(p + 51, 3, 2'b11);
        wait_to(p + 52); chk("t5_state_rel", key_state, 2'b00);
        wait_to(cyc + 10);

        // 6: reset while held restarts the full debounce
        c = cyc; key_in[0] = 1'b0; p = c + 11;
        exp_pair(p, 0, 2'b01);
        wait_to(p + 20);
        chk("t6_state_before_rst", key_state, 2'b01);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {key_state, press_flag, release_flag, long_flag, repeat_flag}, 0);
        chk("t6_rst_outputs_nr", {nr_key_state, nr_press, nr_release, nr_long, nr_repeat}, 0);
        repeat (3) @(negedge sys_clk);
        r = cyc; sys_rst_n = 1'b1;
        exp_pair(r + 11, 0, 2'b01);
        exp_pair(r + 51, 1, 2'b01);
        wait_to(r + 10); chk("t6_state_pre_press", key_state, 2'b00);
        wait_to(r + 51);
        d = cyc; key_in[0] = 1'b1;
        exp_pair(d + 11, 3, 2'b01);
        wait_to(d + 20);

        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
Multi-channel successor to the single-key 20 ms debouncer. It handles NUM_KEYS independent mechanical keys. For each key it provides:
- a two-flop input synchroniser and polarity normalisation;
- symmetric press and release debouncing;
- a debounced level output;
- single-cycle press, release, long-press and auto-repeat pulses.

It sits between the board push-buttons and the spectrum analyzer's UI/control FSMs.

Parameters:
NUM_KEYS, 4, number of independent key channels.
CNT_W, 26, width of the per-channel counters.
DEBOUNCE_CNT, 1_000_000, number of stable sys_clk cycles needed to accept a press or release (20 ms at 50 MHz).
LONG_CNT, 50_000_000, number of HELD cycles before long_flag fires (1 s).
REPEAT_CNT, 5_000_000, period of repeat_flag after long_flag (100 ms).
REPEAT_EN, 1, 1 enables auto-repeat; 0 suppresses repeat_flag.
ACTIVE_LOW, 1, 1 means a key reads 0 when pressed.

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst_n  in  1  reset, asynchronous, active-low.
key_in  in  NUM_KEYS  raw asynchronous key pins.
key_state  out  NUM_KEYS  debounced level, 1 = pressed.
press_flag  out  NUM_KEYS  1-cycle pulse when a press is accepted.
release_flag  out  NUM_KEYS  1-cycle pulse when a release is accepted.
long_flag  out  NUM_KEYS  1-cycle pulse after LONG_CNT cycles in HELD.
repeat_flag  out  NUM_KEYS  1-cycle pulse every REPEAT_CNT cycles after long_flag.

Behaviour:
- Reset, clock and synchroniser:
  - Reset is sys_rst_n, asynchronous, active-low; all logic is clocked on sys_clk rising edge.
  - Reset values: all outputs 0, every channel in IDLE, all counters 0, long_done 0.
  - Both synchroniser flops reset to the released level (1 if ACTIVE_LOW, else 0), so there is no spurious press after reset.
- Normalisation: k_s = synchronised pin, XORed with ACTIVE_LOW so that 1 = pressed.
- Per-channel FSM, states IDLE, PRESS_DB, HELD, RELEASE_DB; db_cnt and hold_cnt are CNT_W bits each.
- IDLE:
  - k_s=1 -> PRESS_DB, db_cnt<=0.
- PRESS_DB:
  - k_s=0 -> IDLE, no flag.
  - Else if db_cnt==DEBOUNCE_CNT-1 -> HELD; press_flag<=1, key_state<=1, hold_cnt<=0, long_done<=0.
  - Else db_cnt++.
- Press latency: counting the edge that first samples pressed key_in as edge 1, press_flag and key_state are registered on edge DEBOUNCE_CNT+3.
- HELD:
  - k_s=0 -> RELEASE_DB, db_cnt<=0; hold_cnt is frozen.
  - Else hold_cnt++, subject to the long/repeat rules below.
- Long-press and repeat (HELD only):
  - long_done=0 and hold_cnt==LONG_CNT-1 -> long_flag<=1, long_done<=1, hold_cnt<=0.
  - long_done=1, REPEAT_EN=1 and hold_cnt==REPEAT_CNT-1 -> repeat_flag<=1, hold_cnt<=0.
  - long_done=1 and REPEAT_EN=0 -> hold_cnt saturates at its terminal count (no wrap).
- RELEASE_DB:
  - key_state stays 1.
  - k_s=1 -> back to HELD; hold_cnt resumes from its frozen value and long_done is kept.
  - Else if db_cnt==DEBOUNCE_CNT-1 -> IDLE; release_flag<=1, key_state<=0.
  - Else db_cnt++.
- Release latency: DEBOUNCE_CNT+3 edges after key_in is first sampled released, mirroring press.
- Every flag is a single-cycle pulse and defaults to 0 in every other cycle.
- Flag exclusivity per channel: press and long, long and repeat, and repeat and release are never asserted in the same cycle.
- Channels are fully independent. Identical stimulus on two channels produces identical, same-cycle flags.
- Reset mid-operation: outputs drop to 0 asynchronously. If a key is still pressed when reset deasserts, it is treated as a fresh press (full debounce applies).
- Constraints, checked at elaboration with a fatal message:
  - DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT >= 2.
  - All three fit in CNT_W bits.
  - NUM_KEYS >= 1.

Decomposition:
- Package key_pkg holds:
  - the state enum (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - default constants KEY_DB_20MS_50M, KEY_LONG_1S_50M and KEY_REP_100MS_50M.
- Sub-module key_channel contains one synchroniser, the FSM and both counters, and is instantiated NUM_KEYS times in a generate loop.
- The top level only slices the buses.

Test Plan:
Bench parameters: NUM_KEYS=2, DEBOUNCE_CNT=8, LONG_CNT=40, REPEAT_CNT=10, ACTIVE_LOW=1.
1. key_in[0] driven low and held -> press_flag[0] pulses on edge 11 and key_state[0] goes 1 on the same edge; channel 1 outputs stay 0.
2. key_in[0] low for 5 cycles, then high, repeated 3 times -> no flags and key_state stays 0; a following stable press gives press_flag on edge 11.
3. Hold key 0 for 100 cycles after press_flag -> long_flag 40 cycles after press_flag, then repeat_flag at +10, +20, … (6 pulses). With REPEAT_EN=0 -> long_flag only.
4. While HELD, a 3-cycle high glitch on key_in[0] -> no release_flag and key_state stays 1. A stable release -> release_flag on edge 11 counted from the first released sample, with key_state falling on the same edge.
5. Identical press waveform on both keys -> press_flag=2'b11 in a single cycle; later long_flag=2'b11 in a single cycle.
6. Reset pulse while key 0 is HELD with key still low -> all outputs 0 immediately; after deassert, press_flag[0] on edge 11 and long_flag timing restarts.
